// File: rtl/cdb_pkg.sv
// Shared definitions for the CDB arbiter slice: default widths, source ids and
// the CDB entry layout.
package cdb_pkg;

  localparam int unsigned CDB_TAG_W  = 4;
  localparam int unsigned CDB_DATA_W = 32;
  localparam int unsigned NSRC       = 3;

  typedef enum logic [1:0] {
    SRC_ALU1 = 2'd0,
    SRC_ALU2 = 2'd1,
    SRC_LSB  = 2'd2
  } src_e;

  typedef struct packed {
    logic [CDB_TAG_W-1:0]  rename;
    logic [CDB_DATA_W-1:0] value;
  } cdb_entry_t;

  // Round-robin successor over the three producers.
  function automatic src_e next_src(input src_e s);
    return (s == SRC_LSB) ? SRC_ALU1 : src_e'(s + 2'd1);
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Producer-result / CDB-broadcast bundle of the arbiter. The slave side is the
// arbiter; the master side is the producer/consumer environment.
interface cdb_arbiter_if
  import cdb_pkg::*;
#(
  parameter int unsigned TAG_W  = CDB_TAG_W,
  parameter int unsigned DATA_W = CDB_DATA_W
);

  logic              alu1_valid;
  logic [TAG_W-1:0]  alu1_rename;
  logic [DATA_W-1:0] alu1_value;
  logic              alu2_valid;
  logic [TAG_W-1:0]  alu2_rename;
  logic [DATA_W-1:0] alu2_value;
  logic              lsb_valid;
  logic [TAG_W-1:0]  lsb_rename;
  logic [DATA_W-1:0] lsb_value;

  logic              alu1_almost_full;
  logic              alu2_almost_full;
  logic              lsb_almost_full;
  logic              cdb_flag;
  logic [TAG_W-1:0]  cdb_rename;
  logic [DATA_W-1:0] cdb_value;
  logic [1:0]        cdb_src;
  logic              overflow_err;

  modport slave (
    input  alu1_valid, alu1_rename, alu1_value,
    input  alu2_valid, alu2_rename, alu2_value,
    input  lsb_valid, lsb_rename, lsb_value,
    output alu1_almost_full, alu2_almost_full, lsb_almost_full,
    output cdb_flag, cdb_rename, cdb_value, cdb_src, overflow_err
  );

  modport master (
    output alu1_valid, alu1_rename, alu1_value,
    output alu2_valid, alu2_rename, alu2_value,
    output lsb_valid, lsb_rename, lsb_value,
    input  alu1_almost_full, alu2_almost_full, lsb_almost_full,
    input  cdb_flag, cdb_rename, cdb_value, cdb_src, overflow_err
  );

endinterface

// File: rtl/cdb_result_fifo.sv
// Per-producer result FIFO. A push while full is accepted when the same cycle
// pops; flush empties it with priority over push and pop.
module cdb_result_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 36
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             en;
  logic             do_push;
  logic             do_pop;

  assign en          = rdy && !flush;
  assign do_pop      = pop && !empty;
  assign do_push     = push && (!full || do_pop);
  assign empty       = (count == '0);
  assign full        = (count == (AW+1)'(DEPTH));
  assign almost_full = (count >= (AW+1)'(DEPTH - 1));
  assign head        = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (rdy) begin
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + 1'b1;
        if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({do_push, do_pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (en && do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: three result FIFOs, round-robin grant of one head
// per cycle, registered CDB broadcast and a sticky overflow flag.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned TAG_W  = CDB_TAG_W,
  parameter int unsigned DATA_W = CDB_DATA_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rdy,
  input  logic          flush,
  cdb_arbiter_if.slave  bus
);

  localparam int unsigned EW = TAG_W + DATA_W;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [NSRC-1:0] push;
  logic [NSRC-1:0] pop;
  logic [NSRC-1:0] empty;
  logic [NSRC-1:0] full;
  logic [NSRC-1:0] afull;
  logic [NSRC-1:0] drop;
  logic [EW-1:0]   push_data [NSRC];
  logic [EW-1:0]   head      [NSRC];
  logic [CW-1:0]   cnt       [NSRC];

  src_e              rr_ptr;
  src_e              grant;
  logic              grant_valid;
  logic [2:0]        sum;
  logic [1:0]        sel;

  logic              cdb_flag_q;
  logic [TAG_W-1:0]  cdb_rename_q;
  logic [DATA_W-1:0] cdb_value_q;
  src_e              cdb_src_q;
  logic              overflow_q;

  assign push         = {bus.lsb_valid, bus.alu2_valid, bus.alu1_valid};
  assign push_data[0] = {bus.alu1_rename, bus.alu1_value};
  assign push_data[1] = {bus.alu2_rename, bus.alu2_value};
  assign push_data[2] = {bus.lsb_rename, bus.lsb_value};

  for (genvar i = 0; i < NSRC; i++) begin : g_fifo
    cdb_result_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (EW)
    ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .rdy         (rdy),
      .flush       (flush),
      .push        (push[i]),
      .push_data   (push_data[i]),
      .pop         (pop[i]),
      .head        (head[i]),
      .empty       (empty[i]),
      .full        (full[i]),
      .almost_full (afull[i]),
      .count       (cnt[i])
    );

    always_ff @(posedge clk) begin
      if (rst) assert (empty[i] == (cnt[i] == '0));
    end
  end

  // Search order starts at rr_ptr and wraps modulo three.
  always_comb begin
    grant_valid = 1'b0;
    grant       = SRC_ALU1;
    sum         = '0;
    sel         = '0;
    for (int unsigned k = 0; k < NSRC; k++) begin
      sum = {1'b0, rr_ptr} + 3'(k);
      if (sum >= 3'(NSRC)) sum = sum - 3'(NSRC);
      sel = sum[1:0];
      if (!grant_valid && !empty[sel]) begin
        grant_valid = 1'b1;
        grant       = src_e'(sel);
      end
    end
  end

  assign pop  = grant_valid ? (3'b001 << grant) : '0;
  assign drop = push & full & ~pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr       <= SRC_ALU1;
      cdb_flag_q   <= 1'b0;
      cdb_rename_q <= '0;
      cdb_value_q  <= '0;
      cdb_src_q    <= SRC_ALU1;
      overflow_q   <= 1'b0;
    end else if (rdy) begin
      if (flush) begin
        rr_ptr     <= SRC_ALU1;
        cdb_flag_q <= 1'b0;
      end else begin
        if (|drop) overflow_q <= 1'b1;
        if (grant_valid) begin
          cdb_flag_q                  <= 1'b1;
          {cdb_rename_q, cdb_value_q} <= head[grant];
          cdb_src_q                   <= grant;
          rr_ptr                      <= next_src(grant);
        end else begin
          cdb_flag_q <= 1'b0;
        end
      end
    end
  end

  assign bus.cdb_flag         = cdb_flag_q;
  assign bus.cdb_rename       = cdb_rename_q;
  assign bus.cdb_value        = cdb_value_q;
  assign bus.cdb_src          = cdb_src_q;
  assign bus.overflow_err     = overflow_q;
  assign bus.alu1_almost_full = afull[0];
  assign bus.alu2_almost_full = afull[1];
  assign bus.lsb_almost_full  = afull[2];

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: a queue-based reference model predicts each
// broadcast; a monitor compares the DUT outputs after every clock edge.
module tb_cdb_arbiter;
  import cdb_pkg::*;

  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic [1:0]            src;
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] val;
  } bc_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rdy = 1'b1;
  logic flush = 1'b0;
  logic [2:0]            v = '0;
  logic [CDB_TAG_W-1:0]  tg [3];
  logic [CDB_DATA_W-1:0] vl [3];

  cdb_entry_t mq [3][$];
  bc_t        exp_q [$];
  int unsigned m_rr;
  logic                  m_flag, m_ovf;
  logic [1:0]            m_src;
  logic [CDB_TAG_W-1:0]  m_tag;
  logic [CDB_DATA_W-1:0] m_val;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cdb_arbiter_if #(.TAG_W(CDB_TAG_W), .DATA_W(CDB_DATA_W)) bus ();

  assign bus.alu1_valid  = v[0];
  assign bus.alu1_rename = tg[0];
  assign bus.alu1_value  = vl[0];
  assign bus.alu2_valid  = v[1];
  assign bus.alu2_rename = tg[1];
  assign bus.alu2_value  = vl[1];
  assign bus.lsb_valid   = v[2];
  assign bus.lsb_rename  = tg[2];
  assign bus.lsb_value   = vl[2];

  cdb_arbiter #(.DEPTH(DEPTH), .TAG_W(CDB_TAG_W), .DATA_W(CDB_DATA_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .rdy   (rdy),
    .flush (flush),
    .bus   (bus)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 3; s++) mq[s].delete();
    exp_q.delete();
    m_rr = 0; m_flag = 1'b0; m_ovf = 1'b0;
    m_src = '0; m_tag = '0; m_val = '0;
  endtask

  // Predict the effect of the coming edge from the current inputs, then let it happen.
  task automatic tick();
    bit found;
    int w;
    cdb_entry_t e;
    if (rst && rdy) begin
      if (flush) begin
        for (int s = 0; s < 3; s++) mq[s].delete();
        m_rr = 0;
        m_flag = 1'b0;
      end else begin
        found = 0; w = 0;
        for (int k = 0; k < 3; k++) begin
          int s;
          s = (int'(m_rr) + k) % 3;
          if (!found && mq[s].size() > 0) begin found = 1; w = s; end
        end
        if (found) begin
          e = mq[w].pop_front();
          m_flag = 1'b1; m_src = 2'(w); m_tag = e.rename; m_val = e.value;
          exp_q.push_back('{src: 2'(w), tag: e.rename, val: e.value});
          m_rr = (w + 1) % 3;
        end else begin
          m_flag = 1'b0;
        end
        for (int s = 0; s < 3; s++) begin
          if (v[s]) begin
            if (mq[s].size() < DEPTH) mq[s].push_back('{rename: tg[s], value: vl[s]});
            else m_ovf = 1'b1;
          end
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [2:0] valid);
    v = valid;
    for (int s = 0; s < 3; s++) begin
      tg[s] = 4'($urandom);
      vl[s] = $urandom;
    end
  endtask

  // Monitor: compare outputs after every edge; pop the scoreboard on each new broadcast.
  initial begin
    logic s_ok;
    bc_t e;
    forever begin
      @(posedge clk);
      s_ok = rst && rdy && !flush;
      #1;
      if (s_ok && bus.cdb_flag) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL bcast_unexpected: got src=%0d tag=%0h val=%0h expected no broadcast",
                   bus.cdb_src, bus.cdb_rename, bus.cdb_value);
        end else begin
          e = exp_q.pop_front();
          chk("bcast", 64'({bus.cdb_src, bus.cdb_rename, bus.cdb_value}), 64'(e));
        end
      end
      chk("cdb_flag", 64'(bus.cdb_flag), 64'(m_flag));
      chk("cdb_hold", 64'({bus.cdb_src, bus.cdb_rename, bus.cdb_value}), 64'({m_src, m_tag, m_val}));
      chk("overflow_err", 64'(bus.overflow_err), 64'(m_ovf));
      chk("almost_full", 64'({bus.lsb_almost_full, bus.alu2_almost_full, bus.alu1_almost_full}),
          64'({mq[2].size() >= DEPTH - 1, mq[1].size() >= DEPTH - 1, mq[0].size() >= DEPTH - 1}));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    for (int s = 0; s < 3; s++) begin tg[s] = '0; vl[s] = '0; end
    model_reset();
    #1;
    chk("reset_outputs", 64'({bus.cdb_flag, bus.cdb_src, bus.cdb_rename, bus.cdb_value,
                              bus.overflow_err, bus.lsb_almost_full, bus.alu2_almost_full,
                              bus.alu1_almost_full}), 64'(0));
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    tick(); tick();

    // Single ALU1 result.
    v = 3'b001; tg[0] = 4'd3; vl[0] = 32'h1234;
    tick();
    v = '0;
    repeat (3) tick();

    // Simultaneous push from all sources with pointer cleared by a flush.
    flush = 1'b1; tick(); flush = 1'b0;
    v = 3'b111; tg[0] = 4'd1; tg[1] = 4'd2; tg[2] = 4'd3;
    vl[0] = 32'hA1; vl[1] = 32'hA2; vl[2] = 32'hA3;
    tick();
    v = '0;
    repeat (4) tick();

    // ALU1/ALU2 saturating with a single LSB push.
    drive(3'b111); tick();
    repeat (8) begin drive(3'b011); tick(); end
    v = '0; repeat (6) tick();

    // All sources every cycle: FIFOs fill, pushes to full drop or ride a pop.
    flush = 1'b1; tick(); flush = 1'b0;
    repeat (12) begin drive(3'b111); tick(); end
    v = '0; repeat (10) tick();

    // Flush with two entries queued plus a same-cycle push.
    drive(3'b111); tick();
    drive(3'b001); flush = 1'b1; tick();
    flush = 1'b0; v = '0;
    repeat (4) tick();

    // rdy low with entries queued; valids present but ignored.
    drive(3'b111); tick();
    rdy = 1'b0;
    repeat (3) begin drive(3'b111); tick(); end
    rdy = 1'b1; v = '0;
    repeat (5) tick();

    // Randomised traffic with an asynchronous reset in the middle.
    for (int i = 0; i < 400; i++) begin
      rdy   = ($urandom_range(0, 9) != 0);
      flush = ($urandom_range(0, 39) == 0);
      drive(3'($urandom));
      if (i == 200) begin
        #2 rst = 1'b0;
        #1;
        chk("rst_async", 64'({bus.cdb_flag, bus.cdb_src, bus.cdb_rename, bus.cdb_value,
                              bus.overflow_err, bus.lsb_almost_full, bus.alu2_almost_full,
                              bus.alu1_almost_full}), 64'(0));
        model_reset();
        @(negedge clk);
        rst = 1'b1;
      end
      tick();
    end

    rdy = 1'b1; flush = 1'b0; v = '0;
    repeat (10) tick();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) among three result producers: ALU1, ALU2 and the load/store buffer.
- Each producer's results land in a small per-source FIFO. A round-robin arbiter grants one head entry per cycle.
- The grant drives the registered CDB broadcast consumed by the reservation station (rs_update_flag/rs_commit_rename/rs_value) and the ROB.
- Almost-full flags back-pressure the reservation station's dispatch to each producer.

Parameters:
DEPTH, 4, entries per source FIFO (power of two, >=2)
TAG_W, 4, ROB rename tag width
DATA_W, 32, result value width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
rdy  in  1  global enable; low freezes all state
flush  in  1  mispredict flush from predictor
alu1_valid  in  1  ALU1 result valid this cycle
alu1_rename  in  TAG_W  ROB tag of ALU1 result
alu1_value  in  DATA_W  ALU1 result
alu2_valid  in  1  ALU2 result valid
alu2_rename  in  TAG_W  ROB tag of ALU2 result
alu2_value  in  DATA_W  ALU2 result
lsb_valid  in  1  LSB result valid
lsb_rename  in  TAG_W  ROB tag of LSB result
lsb_value  in  DATA_W  LSB result
alu1_almost_full  out  1  ALU1 FIFO count >= DEPTH-1
alu2_almost_full  out  1  ALU2 FIFO count >= DEPTH-1
lsb_almost_full  out  1  LSB FIFO count >= DEPTH-1
cdb_flag  out  1  broadcast valid
cdb_rename  out  TAG_W  broadcast ROB tag
cdb_value  out  DATA_W  broadcast value
cdb_src  out  2  granted source: 0 = ALU1, 1 = ALU2, 2 = LSB
overflow_err  out  1  sticky: a push was dropped

Behaviour:
- Reset (rst low, asynchronous):
  - All FIFOs empty; RR pointer = 0.
  - cdb_flag = 0, cdb_rename = 0, cdb_value = 0, cdb_src = 0, overflow_err = 0.
  - All almost_full flags = 0.
  - Reset asserted mid-operation discards all buffered results.
- rdy low:
  - No state changes; outputs hold.
  - *_valid inputs are ignored, because all producers are frozen by the same rdy.
- flush high (rdy high):
  - All FIFOs emptied, RR pointer = 0, cdb_flag <= 0, overflow_err unchanged.
  - Flush has priority over pushes and the pop in the same cycle.
- Push: *_valid high at edge t writes {rename, value} into that source's FIFO. Up to three pushes per cycle, one per source.
- Arbitration (combinational, each cycle):
  - Candidates are sources with a non-empty FIFO.
  - Search starts at the RR pointer in order 0, 1, 2, wrapping.
  - The first candidate wins.
- Pop / broadcast, registered:
  - At the edge, the winner's head is popped.
  - cdb_flag <= 1, cdb_rename/cdb_value <= head, cdb_src <= winner id.
  - RR pointer <= (winner + 1) mod 3.
  - With no candidate: cdb_flag <= 0, other CDB outputs hold, pointer holds.
- Latency: a result pushed at edge t is broadcast at the earliest at edge t+1, i.e. cdb_flag is high in the cycle after t+1. There is no bypass path.
- Full FIFO:
  - A push to a full FIFO in a cycle where that same FIFO is popped is accepted.
  - Otherwise the push is dropped and overflow_err <= 1, cleared only by reset.
- Almost-full:
  - Registered-count based: the flag is high when count >= DEPTH-1.
  - This gives the reservation station one cycle of slack for an already-registered mission.
- Pointer wrap: FIFO read/write pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
- Starvation bound: any non-empty source is granted within 3 cycles.
- Duplicate tags from different sources are not checked; each is broadcast in grant order.

Decomposition:
- Shared package cdb_pkg:
  - TAG_W and DATA_W defaults.
  - Source ids SRC_ALU1 = 0, SRC_ALU2 = 1, SRC_LSB = 2, NSRC = 3.
  - The CDB entry struct {rename, value}.
- Sub-module cdb_result_fifo, instantiated three times:
  - Ports: clk, rst, rdy, flush, push, push_data, pop, head, empty, full, almost_full, count.
  - Push-while-full-and-pop is legal.
- Top level: RR pointer, grant logic, output registers, overflow_err.

Test Plan:
- Reset release; single alu1 push {tag 3, 0x1234} at edge 5 -> cdb_flag high in the cycle after edge 6, cdb_rename = 3, cdb_value = 0x1234, cdb_src = 0; cdb_flag low the following cycle.
- All three sources push {tags 1, 2, 3} in the same cycle with pointer 0 -> broadcasts on 3 consecutive cycles with cdb_src 0, 1, 2; pointer ends at 0.
- alu1 pushes every cycle, lsb pushes once -> lsb granted within 3 cycles; alu1_almost_full asserts when count reaches 3 (DEPTH = 4).
- Fill alu2 to 4 with pointer parked on alu1 traffic, push again -> entry dropped, overflow_err = 1 and sticky. Repeat with a simultaneous alu2 pop -> accepted, overflow_err unchanged.
- flush with 2 entries queued plus a same-cycle push -> next cycle cdb_flag = 0, all FIFOs empty, no later broadcast of those tags.
- rdy low for 3 cycles with entries queued -> CDB outputs frozen, no pop. rst pulled low mid-stream -> outputs 0 immediately, without waiting for a clock edge.
